msf_encoder: RTL

MSF_ENCODER -- requirements
Module: msf_encoder

---
 rtl/msf_encoder.sv | 84 ++++++++
 1 files changed

// File: rtl/msf_encoder.sv
// MSF time-signal encoder: turns buffered second-words into ten 100 ms carrier samples per second.
// A one-entry word buffer is drained at each slot-0 tick; an empty buffer yields an all-ones second.
module msf_encoder (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       bits_valid_i,
  output logic       bits_ready_o,
  input  logic       bits_is_second_00_i,
  input  logic [1:0] bits_data_i,
  output logic       sample_valid_o,
  output logic       sample_data_o,
  output logic       second_start_o,
  output logic       underrun_o
);

  logic       full;
  logic       buf_is_00;
  logic [1:0] buf_data;
  logic [3:0] slot;
  logic [9:0] pattern;

  logic       handshake;
  logic       slot_zero;
  logic [9:0] word_pattern;
  logic [9:0] next_pattern;
  logic       slot_level;

  assign bits_ready_o = !full;
  assign handshake    = bits_valid_i && !full;
  assign slot_zero    = (slot == 4'd0);

  // Bit i of a pattern is the carrier level for slot i.
  always_comb begin
    word_pattern = 10'h3FF;
    if (buf_is_00) begin
      word_pattern = 10'b11111_00000;
    end else begin
      word_pattern[0] = 1'b0;
      word_pattern[1] = buf_data[0];
      word_pattern[2] = buf_data[1];
    end
  end

  // A new second is chosen only at slot 0; a word arriving in that same cycle waits a second.
  always_comb begin
    next_pattern = pattern;
    if (slot_zero) begin
      next_pattern = full ? word_pattern : 10'h3FF;
    end
    slot_level = next_pattern[slot];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full           <= 1'b0;
      buf_is_00      <= 1'b0;
      buf_data       <= 2'b00;
      slot           <= 4'd0;
      pattern        <= 10'h3FF;
      sample_valid_o <= 1'b0;
      sample_data_o  <= 1'b1;
      second_start_o <= 1'b0;
      underrun_o     <= 1'b0;
    end else begin
      sample_valid_o <= tick_i;
      second_start_o <= tick_i && slot_zero;
      underrun_o     <= tick_i && slot_zero && !full;
      if (tick_i) begin
        sample_data_o <= slot_level;
        pattern       <= next_pattern;
        slot          <= (slot == 4'd9) ? 4'd0 : slot + 4'd1;
      end
      if (tick_i && slot_zero && full) begin
        full <= 1'b0;
      end else if (handshake) begin
        full      <= 1'b1;
        buf_is_00 <= bits_is_second_00_i;
        buf_data  <= bits_data_i;
      end
    end
  end

endmodule
